mem_stage_sram_ctrl: RTL and testbench

//  MEM-stage data-memory controller. Sits between the EXE/MEM pipeline register and the MEM/WB

---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_stage_sram_ctrl.sv | 131 +++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: FSM state encoding,
// default address base and the external SRAM geometry.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } memState_e;

    localparam int unsigned ADDR_BASE_DEFAULT   = 1024;
    localparam int unsigned SRAM_AW_DEFAULT     = 18;
    localparam int unsigned SRAM_DW             = 16;
    localparam int unsigned WAIT_CYCLES_DEFAULT = 5;

endpackage

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory controller: splits each 32-bit load/store into two
// timed 16-bit accesses on an asynchronous SRAM and freezes the pipeline meanwhile.
module mem_stage_sram_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_BASE   = ADDR_BASE_DEFAULT,
    parameter int unsigned SRAM_AW     = SRAM_AW_DEFAULT,
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        address,
    input  logic [31:0]        st_val,
    output logic               ready,
    output logic [31:0]        read_data,
    inout  wire  [SRAM_DW-1:0] sram_dq,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WE_LAST  = CNT_W'(WAIT_CYCLES - 2);

    memState_e          stateQ, stateD;
    logic [CNT_W-1:0]   cntQ, cntD;
    logic [SRAM_AW-2:0] waddrQ, waddrD;
    logic [31:0]        stValQ, stValD;
    logic               isWriteQ, isWriteD;
    logic [15:0]        lo16Q, lo16D;
    logic [31:0]        readDataQ, readDataD;

    logic               req;
    logic               busy;
    logic               phaseEnd;
    logic [31:0]        offset;
    logic               unusedOffsetBits;
    logic               driveDq;
    logic [15:0]        dqOut;

    assign req      = mem_r_en | mem_w_en;
    assign busy     = (stateQ == LOW) || (stateQ == HIGH);
    assign phaseEnd = (cntQ == CNT_LAST);

    // Byte address relative to the SRAM window, as 32-bit word index.
    assign offset           = address - 32'(ADDR_BASE);
    assign unusedOffsetBits = ^{offset[31:SRAM_AW+1], offset[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ    <= IDLE;
            cntQ      <= '0;
            waddrQ    <= '0;
            stValQ    <= '0;
            isWriteQ  <= 1'b0;
            lo16Q     <= '0;
            readDataQ <= '0;
        end else begin
            stateQ    <= stateD;
            cntQ      <= cntD;
            waddrQ    <= waddrD;
            stValQ    <= stValD;
            isWriteQ  <= isWriteD;
            lo16Q     <= lo16D;
            readDataQ <= readDataD;
        end
    end

    always_comb begin
        stateD    = stateQ;
        cntD      = cntQ;
        waddrD    = waddrQ;
        stValD    = stValQ;
        isWriteD  = isWriteQ;
        lo16D     = lo16Q;
        readDataD = readDataQ;
        case (stateQ)
            IDLE: begin
                if (req) begin
                    waddrD   = offset[SRAM_AW:2];
                    stValD   = st_val;
                    isWriteD = mem_w_en;
                    cntD     = '0;
                    stateD   = LOW;
                end
            end
            LOW: begin
                if (phaseEnd) begin
                    cntD   = '0;
                    stateD = HIGH;
                    if (!isWriteQ) lo16D = sram_dq;
                end else begin
                    cntD = cntQ + CNT_W'(1);
                end
            end
            HIGH: begin
                if (phaseEnd) begin
                    cntD   = '0;
                    stateD = DONE;
                    if (!isWriteQ) readDataD = {sram_dq, lo16Q};
                end else begin
                    cntD = cntQ + CNT_W'(1);
                end
            end
            // The request is still held by the same instruction here, so it is ignored.
            DONE:    stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    // Write strobe leaves one setup cycle and one hold cycle around the pulse.
    always_comb begin
        ready     = 1'b0;
        sram_we_n = 1'b1;
        sram_oe_n = 1'b1;
        driveDq   = busy && isWriteQ;
        dqOut     = (stateQ == HIGH) ? stValQ[31:16] : stValQ[15:0];
        if (stateQ == IDLE) ready = ~req;
        if (stateQ == DONE) ready = 1'b1;
        if (busy && isWriteQ && (cntQ != '0) && (cntQ <= WE_LAST)) sram_we_n = 1'b0;
        if (busy && !isWriteQ) sram_oe_n = 1'b0;
    end

    assign sram_addr = {waddrQ, (stateQ == HIGH)};
    assign sram_dq   = driveDq ? dqOut : {SRAM_DW{1'bz}};
    assign read_data = readDataQ;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with an inline asynchronous SRAM model
// that commits a write on the rising edge of we_n unless reset aborted it.
module tb_mem_stage_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] address;
    logic [31:0] st_val;
    logic        ready;
    logic [31:0] read_data;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic        sram_oe_n;

    int checkCount = 0;
    int errorCount = 0;

    logic [15:0] sramMem [0:(1<<18)-1];
    logic [17:0] wAddr = '0;
    logic [15:0] wData = '0;

    mem_stage_sram_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .mem_r_en  (mem_r_en),
        .mem_w_en  (mem_w_en),
        .address   (address),
        .st_val    (st_val),
        .ready     (ready),
        .read_data (read_data),
        .sram_dq   (sram_dq),
        .sram_addr (sram_addr),
        .sram_we_n (sram_we_n),
        .sram_oe_n (sram_oe_n)
    );

    always #5 clk = ~clk;

    // SRAM model: reads are combinational, writes latch while we_n is low.
    assign sram_dq = (!sram_oe_n && sram_we_n) ? sramMem[sram_addr] : 16'hzzzz;

    always @(negedge clk) begin
        if (!sram_we_n) begin
            wAddr <= sram_addr;
            wData <= sram_dq;
        end
    end

    always @(posedge sram_we_n) begin
        if (!rst) sramMem[wAddr] = wData;
    end

    function automatic bit dqIsFree();
        return (sram_dq === 16'hzzzz) || (sram_dq === 16'h0000);
    endfunction

    // Drives one request and counts ready-low cycles until DONE (bounded).
    task automatic runAccess(input bit alignNeg, input bit rEn, input bit wEn,
                             input logic [31:0] addr, input logic [31:0] data,
                             output int lowCycles, output int weLow, output int oeLow);
        if (alignNeg) @(negedge clk);
        mem_r_en = rEn;
        mem_w_en = wEn;
        address  = addr;
        st_val   = data;
        #1;
        lowCycles = 0;
        weLow     = 0;
        oeLow     = 0;
        while (ready !== 1'b1 && lowCycles < 100) begin
            if (sram_we_n === 1'b0) weLow++;
            if (sram_oe_n === 1'b0) oeLow++;
            lowCycles++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic setIdle();
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checkCount += 6;
        if (ready !== 1'b1) begin
            errorCount++; $display("[TB] FAIL reset_ready got %b expected 1", ready);
        end
        if (read_data !== 32'h0) begin
            errorCount++; $display("[TB] FAIL reset_read_data got %h expected 00000000", read_data);
        end
        if (sram_we_n !== 1'b1) begin
            errorCount++; $display("[TB] FAIL reset_we_n got %b expected 1", sram_we_n);
        end
        if (sram_oe_n !== 1'b1) begin
            errorCount++; $display("[TB] FAIL reset_oe_n got %b expected 1", sram_oe_n);
        end
        if (sram_addr !== 18'h0) begin
            errorCount++; $display("[TB] FAIL reset_addr got %h expected 0", sram_addr);
        end
        if (!dqIsFree()) begin
            errorCount++; $display("[TB] FAIL reset_dq got %h expected Z", sram_dq);
        end
        rst = 1'b0;
    endtask

    task automatic test_store_load();
        int lowC, weC, oeC;
        runAccess(1'b1, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, lowC, weC, oeC);
        checkCount += 5;
        if (lowC !== 11) begin
            errorCount++; $display("[TB] FAIL store_latency got %0d expected 11", lowC);
        end
        if (weC !== 6) begin
            errorCount++; $display("[TB] FAIL store_we_cycles got %0d expected 6", weC);
        end
        if (oeC !== 0) begin
            errorCount++; $display("[TB] FAIL store_oe_cycles got %0d expected 0", oeC);
        end
        if (sramMem[0] !== 16'hBEEF) begin
            errorCount++; $display("[TB] FAIL store_lo got %h expected BEEF", sramMem[0]);
        end
        if (sramMem[1] !== 16'hDEAD) begin
            errorCount++; $display("[TB] FAIL store_hi got %h expected DEAD", sramMem[1]);
        end
        setIdle();
        runAccess(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, lowC, weC, oeC);
        checkCount += 4;
        if (lowC !== 11) begin
            errorCount++; $display("[TB] FAIL load_latency got %0d expected 11", lowC);
        end
        if (read_data !== 32'hDEADBEEF) begin
            errorCount++; $display("[TB] FAIL load_data got %h expected DEADBEEF", read_data);
        end
        if (oeC !== 10) begin
            errorCount++; $display("[TB] FAIL load_oe_cycles got %0d expected 10", oeC);
        end
        if (weC !== 0) begin
            errorCount++; $display("[TB] FAIL load_we_cycles got %0d expected 0", weC);
        end
        setIdle();
    endtask

    task automatic test_address_map();
        int lowC, weC, oeC;
        runAccess(1'b1, 1'b0, 1'b1, 32'd1032, 32'h12345678, lowC, weC, oeC);
        checkCount += 2;
        if (sramMem[4] !== 16'h5678) begin
            errorCount++; $display("[TB] FAIL map_lo got %h expected 5678", sramMem[4]);
        end
        if (sramMem[5] !== 16'h1234) begin
            errorCount++; $display("[TB] FAIL map_hi got %h expected 1234", sramMem[5]);
        end
        setIdle();
    endtask

    task automatic test_no_request();
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        address  = 32'd1024;
        st_val   = 32'hFFFFFFFF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkCount++;
            if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || !dqIsFree()) begin
                errorCount++;
                $display("[TB] FAIL no_request cycle %0d got ready=%b we_n=%b oe_n=%b dq=%h expected 1 1 1 Z",
                         i, ready, sram_we_n, sram_oe_n, sram_dq);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lowC, weC, oeC, gap;
        runAccess(1'b1, 1'b0, 1'b1, 32'd1028, 32'h11223344, lowC, weC, oeC);
        setIdle();
        runAccess(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, lowC, weC, oeC);
        checkCount += 2;
        if (lowC !== 11) begin
            errorCount++; $display("[TB] FAIL b2b_first_latency got %0d expected 11", lowC);
        end
        if (read_data !== 32'hDEADBEEF) begin
            errorCount++; $display("[TB] FAIL b2b_first_data got %h expected DEADBEEF", read_data);
        end
        address = 32'd1028;
        gap = 0;
        while (ready === 1'b1 && gap < 10) begin
            gap++;
            @(negedge clk);
            #1;
        end
        runAccess(1'b0, 1'b1, 1'b0, 32'd1028, 32'h0, lowC, weC, oeC);
        checkCount += 3;
        if (gap !== 1) begin
            errorCount++; $display("[TB] FAIL b2b_gap got %0d expected 1", gap);
        end
        if (lowC !== 11) begin
            errorCount++; $display("[TB] FAIL b2b_second_latency got %0d expected 11", lowC);
        end
        if (read_data !== 32'h11223344) begin
            errorCount++; $display("[TB] FAIL b2b_second_data got %h expected 11223344", read_data);
        end
        setIdle();
    endtask

    task automatic test_both_enables();
        int lowC, weC, oeC;
        runAccess(1'b1, 1'b1, 1'b1, 32'd1024, 32'h0000A5A5, lowC, weC, oeC);
        checkCount += 6;
        if (lowC !== 11) begin
            errorCount++; $display("[TB] FAIL both_latency got %0d expected 11", lowC);
        end
        if (weC !== 6) begin
            errorCount++; $display("[TB] FAIL both_we_cycles got %0d expected 6", weC);
        end
        if (oeC !== 0) begin
            errorCount++; $display("[TB] FAIL both_oe_cycles got %0d expected 0", oeC);
        end
        if (read_data !== 32'h11223344) begin
            errorCount++; $display("[TB] FAIL both_read_data got %h expected 11223344", read_data);
        end
        if (sramMem[0] !== 16'hA5A5) begin
            errorCount++; $display("[TB] FAIL both_lo got %h expected A5A5", sramMem[0]);
        end
        if (sramMem[1] !== 16'h0000) begin
            errorCount++; $display("[TB] FAIL both_hi got %h expected 0000", sramMem[1]);
        end
        setIdle();
    endtask

    task automatic test_reset_mid_store();
        @(negedge clk);
        mem_r_en = 1'b0;
        mem_w_en = 1'b1;
        address  = 32'd1024;
        st_val   = 32'hCAFEF00D;
        repeat (8) @(negedge clk);
        #1;
        checkCount++;
        if (sram_we_n !== 1'b0) begin
            errorCount++; $display("[TB] FAIL midstore_pulse got we_n=%b expected 0", sram_we_n);
        end
        rst      = 1'b1;
        mem_w_en = 1'b0;
        #1;
        checkCount += 5;
        if (sram_we_n !== 1'b1) begin
            errorCount++; $display("[TB] FAIL midstore_we_n got %b expected 1", sram_we_n);
        end
        if (!dqIsFree()) begin
            errorCount++; $display("[TB] FAIL midstore_dq got %h expected Z", sram_dq);
        end
        if (ready !== 1'b1) begin
            errorCount++; $display("[TB] FAIL midstore_ready got %b expected 1", ready);
        end
        if (read_data !== 32'h0) begin
            errorCount++; $display("[TB] FAIL midstore_read_data got %h expected 00000000", read_data);
        end
        if (sram_oe_n !== 1'b1) begin
            errorCount++; $display("[TB] FAIL midstore_oe_n got %b expected 1", sram_oe_n);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkCount += 2;
        if (sramMem[0] !== 16'hF00D) begin
            errorCount++; $display("[TB] FAIL midstore_lo got %h expected F00D", sramMem[0]);
        end
        if (sramMem[1] !== 16'h0000) begin
            errorCount++; $display("[TB] FAIL midstore_hi got %h expected 0000", sramMem[1]);
        end
    endtask

    initial begin
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        address  = 32'h0;
        st_val   = 32'h0;
        for (int i = 0; i < 8; i++) sramMem[i] = 16'h0000;
        test_reset();
        test_store_load();
        test_address_map();
        test_no_request();
        test_back_to_back();
        test_both_enables();
        test_reset_mid_store();
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
